// File: rtl/fp_wb_arbiter.sv
// ----------------------------------------------------------------------------
// fp_wb_arbiter
//
// Merges the two FP intermediate writeback sources into one registered
// writeback port toward the FP writeback/normalize stage.
//   Source 0 : fused add/madd path (default priority, so the longer FMA
//              pipeline drains first)
//   Source 1 : standalone multiply path
// A one-entry output register decouples the sources from downstream
// backpressure; a held result can be drained and replaced on the same edge.
//
// Optional feature (macro FP_WB_ARB_STARVATION_EN):
//   A 4-bit counter tracks consecutive arbitrations the mul source lost to
//   madd. Once it reaches STARVE_LIMIT, mul wins the next accepted cycle.
//   With the macro undefined, pure fixed priority applies.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   madd_done/id/rd/fflags   madd source request and payload (held until ack)
//   madd_ack                 madd result captured this cycle (combinational)
//   mul_done/id/rd/fflags    mul source request and payload (held until ack)
//   mul_ack                  mul result captured this cycle (combinational)
//   wb_valid/id/rd/fflags    registered output result
//   wb_src                   0 = madd, 1 = mul
//   wb_ack                   downstream consumed the held result this cycle
// ----------------------------------------------------------------------------
module fp_wb_arbiter #(
    parameter int unsigned FLEN         = 64,
    parameter int unsigned ID_WIDTH     = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                madd_done,
    input  logic [ID_WIDTH-1:0] madd_id,
    input  logic [FLEN-1:0]     madd_rd,
    input  logic [4:0]          madd_fflags,
    output logic                madd_ack,

    input  logic                mul_done,
    input  logic [ID_WIDTH-1:0] mul_id,
    input  logic [FLEN-1:0]     mul_rd,
    input  logic [4:0]          mul_fflags,
    output logic                mul_ack,

    output logic                wb_valid,
    output logic [ID_WIDTH-1:0] wb_id,
    output logic [FLEN-1:0]     wb_rd,
    output logic [4:0]          wb_fflags,
    output logic                wb_src,
    input  logic                wb_ack
);

    // ------------------------------------------------------------------------
    // Output register state
    // ------------------------------------------------------------------------
    logic                wb_valid_q, wb_valid_d;
    logic [ID_WIDTH-1:0] wb_id_q,    wb_id_d;
    logic [FLEN-1:0]     wb_rd_q,    wb_rd_d;
    logic [4:0]          wb_fflags_q, wb_fflags_d;
    logic                wb_src_q,   wb_src_d;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    logic can_accept;
    logic force_mul;
    logic grant_madd;
    logic grant_mul;

    // Register is free when empty or being drained this same cycle. Reset
    // blocks acceptance so no source is acked while rst is held.
    assign can_accept = ~rst & (~wb_valid_q | wb_ack);

`ifdef FP_WB_ARB_STARVATION_EN
    // Consecutive lost arbitrations of a waiting mul result; saturates at
    // the limit, which then overrides the madd priority.
    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;

    assign force_mul = mul_done & can_accept & (starve_cnt_q == StarveLimit);
`else
    // Limit only matters with the starvation counter present.
    logic [3:0] unused_starve_limit;
    assign unused_starve_limit = 4'(STARVE_LIMIT);

    assign force_mul = 1'b0;
`endif

    always_comb begin
        grant_madd = 1'b0;
        grant_mul  = 1'b0;
        if (can_accept) begin
            if (force_mul) begin
                grant_mul = 1'b1;
            end else if (madd_done) begin
                grant_madd = 1'b1;
            end else if (mul_done) begin
                grant_mul = 1'b1;
            end
        end
    end

    assign madd_ack = grant_madd;
    assign mul_ack  = grant_mul;

`ifdef FP_WB_ARB_STARVATION_EN
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!mul_done || grant_mul) begin
            starve_cnt_d = 4'd0;
        end else if (grant_madd && (starve_cnt_q != StarveLimit)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Output register next state
    // ------------------------------------------------------------------------
    always_comb begin
        wb_valid_d  = wb_valid_q;
        wb_id_d     = wb_id_q;
        wb_rd_d     = wb_rd_q;
        wb_fflags_d = wb_fflags_q;
        wb_src_d    = wb_src_q;
        if (grant_madd) begin
            // Refill covers the same-cycle drain case as well.
            wb_valid_d  = 1'b1;
            wb_id_d     = madd_id;
            wb_rd_d     = madd_rd;
            wb_fflags_d = madd_fflags;
            wb_src_d    = 1'b0;
        end else if (grant_mul) begin
            wb_valid_d  = 1'b1;
            wb_id_d     = mul_id;
            wb_rd_d     = mul_rd;
            wb_fflags_d = mul_fflags;
            wb_src_d    = 1'b1;
        end else if (wb_ack) begin
            // Data fields keep their last value once drained.
            wb_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            wb_id_q     <= '0;
            wb_rd_q     <= '0;
            wb_fflags_q <= 5'd0;
            wb_src_q    <= 1'b0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            wb_id_q     <= wb_id_d;
            wb_rd_q     <= wb_rd_d;
            wb_fflags_q <= wb_fflags_d;
            wb_src_q    <= wb_src_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_id     = wb_id_q;
    assign wb_rd     = wb_rd_q;
    assign wb_fflags = wb_fflags_q;
    assign wb_src    = wb_src_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fp_wb_arbiter
//
// Directed scenarios followed by a randomized run. A behavioural model of the
// one-entry writeback slot (plus the mul waiting streak when the starvation
// macro FP_WB_ARB_STARVATION_EN is defined) predicts acks and wb_* contents.
// ----------------------------------------------------------------------------
module tb_fp_wb_arbiter;

    localparam int FLEN  = 64;
    localparam int IDW   = 3;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            madd_done = 1'b0;
    logic [IDW-1:0]  madd_id = '0;
    logic [FLEN-1:0] madd_rd = '0;
    logic [4:0]      madd_fflags = '0;
    logic            madd_ack;
    logic            mul_done = 1'b0;
    logic [IDW-1:0]  mul_id = '0;
    logic [FLEN-1:0] mul_rd = '0;
    logic [4:0]      mul_fflags = '0;
    logic            mul_ack;
    logic            wb_valid;
    logic [IDW-1:0]  wb_id;
    logic [FLEN-1:0] wb_rd;
    logic [4:0]      wb_fflags;
    logic            wb_src;
    logic            wb_ack = 1'b0;

    always #5 clk = ~clk;

    fp_wb_arbiter #(
        .FLEN         (FLEN),
        .ID_WIDTH     (IDW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .madd_done   (madd_done),
        .madd_id     (madd_id),
        .madd_rd     (madd_rd),
        .madd_fflags (madd_fflags),
        .madd_ack    (madd_ack),
        .mul_done    (mul_done),
        .mul_id      (mul_id),
        .mul_rd      (mul_rd),
        .mul_fflags  (mul_fflags),
        .mul_ack     (mul_ack),
        .wb_valid    (wb_valid),
        .wb_id       (wb_id),
        .wb_rd       (wb_rd),
        .wb_fflags   (wb_fflags),
        .wb_src      (wb_src),
        .wb_ack      (wb_ack)
    );

    int checks = 0;
    int errors = 0;

    // Model of the output slot and of how long mul has been waiting.
    logic            m_valid = 1'b0;
    logic [IDW-1:0]  m_id = '0;
    logic [FLEN-1:0] m_rd = '0;
    logic [4:0]      m_ff = '0;
    logic            m_src = 1'b0;
    int              m_streak = 0;
    logic            g_madd = 1'b0;
    logic            g_mul = 1'b0;

    // Observations captured mid-cycle by run_cycle.
    logic            o_madd_ack, o_mul_ack, o_valid, o_src;
    logic [IDW-1:0]  o_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic predict();
        logic ca;
        logic starve;
        ca = !m_valid || wb_ack;
        starve = 1'b0;
`ifdef FP_WB_ARB_STARVATION_EN
        starve = (m_streak >= LIMIT) && mul_done;
`endif
        g_mul  = ca && mul_done && (starve || !madd_done);
        g_madd = ca && madd_done && !g_mul;
    endtask

    // Called at posedge+1 with inputs applied; returns at next posedge+1.
    task automatic run_cycle();
        #4;
        predict();
        o_madd_ack = madd_ack;
        o_mul_ack  = mul_ack;
        o_valid    = wb_valid;
        o_src      = wb_src;
        o_id       = wb_id;
        chk("madd_ack", 64'(madd_ack), 64'(g_madd));
        chk("mul_ack", 64'(mul_ack), 64'(g_mul));
        chk("wb_valid", 64'(wb_valid), 64'(m_valid));
        chk("wb_id", 64'(wb_id), 64'(m_id));
        chk("wb_rd", wb_rd, m_rd);
        chk("wb_fflags", 64'(wb_fflags), 64'(m_ff));
        chk("wb_src", 64'(wb_src), 64'(m_src));
        @(posedge clk);
        #1;
        if (g_madd) begin
            m_valid = 1'b1; m_id = madd_id; m_rd = madd_rd; m_ff = madd_fflags; m_src = 1'b0;
        end else if (g_mul) begin
            m_valid = 1'b1; m_id = mul_id; m_rd = mul_rd; m_ff = mul_fflags; m_src = 1'b1;
        end else if (wb_ack) begin
            m_valid = 1'b0;
        end
        if (!mul_done || g_mul) m_streak = 0;
        else if (g_madd && m_streak < LIMIT) m_streak++;
    endtask

    task automatic new_madd();
        madd_id     = IDW'($urandom);
        madd_rd     = {$urandom, $urandom};
        madd_fflags = 5'($urandom);
    endtask

    task automatic new_mul();
        mul_id     = IDW'($urandom);
        mul_rd     = {$urandom, $urandom};
        mul_fflags = 5'($urandom);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_id = '0; m_rd = '0; m_ff = '0; m_src = 1'b0;
        m_streak = 0; g_madd = 1'b0; g_mul = 1'b0;
    endtask

    initial begin
        int mul_ack_at[$];

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (10) run_cycle();

        // Single mul result.
        mul_done = 1'b1; mul_id = 3'd5; mul_rd = 64'h3FF0_0000_0000_0000; mul_fflags = 5'h01;
        wb_ack = 1'b1;
        run_cycle();
        chk("single_mul_ack", 64'(o_mul_ack), 64'd1);
        mul_done = 1'b0;
        run_cycle();
        chk("single_wb_valid", 64'(o_valid), 64'd1);
        chk("single_wb_id", 64'(o_id), 64'd5);
        chk("single_wb_src", 64'(o_src), 64'd1);
        run_cycle();
        chk("single_drained", 64'(o_valid), 64'd0);

        // Contention: madd first, then mul.
        madd_done = 1'b1; madd_id = 3'd2; madd_rd = 64'h4000_0000_0000_0000; madd_fflags = 5'h10;
        mul_done = 1'b1; mul_id = 3'd6; mul_rd = 64'hC008_0000_0000_0000; mul_fflags = 5'h04;
        run_cycle();
        chk("cont_madd_first", 64'(o_madd_ack), 64'd1);
        chk("cont_mul_waits", 64'(o_mul_ack), 64'd0);
        madd_done = 1'b0;
        run_cycle();
        chk("cont_mul_second", 64'(o_mul_ack), 64'd1);
        chk("cont_src0", 64'(o_src), 64'd0);
        mul_done = 1'b0;
        run_cycle();
        chk("cont_src1", 64'(o_src), 64'd1);

        // Backpressure.
        wb_ack = 1'b0;
        madd_done = 1'b1; madd_id = 3'd1; new_madd(); madd_id = 3'd1;
        run_cycle();
        madd_id = 3'd3; madd_rd = 64'h1234_5678_9ABC_DEF0;
        repeat (5) begin
            run_cycle();
            chk("bp_no_ack", 64'(o_madd_ack), 64'd0);
            chk("bp_hold_id", 64'(o_id), 64'd1);
        end
        wb_ack = 1'b1;
        run_cycle();
        chk("bp_drain_refill_ack", 64'(o_madd_ack), 64'd1);
        wb_ack = 1'b0; madd_done = 1'b0;
        run_cycle();
        chk("bp_refill_valid", 64'(o_valid), 64'd1);
        chk("bp_refill_id", 64'(o_id), 64'd3);

        // Asynchronous reset while the slot is full and madd is pending.
        madd_done = 1'b1; new_madd();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(wb_valid), 64'd0);
        chk("arst_id", 64'(wb_id), 64'd0);
        chk("arst_rd", wb_rd, 64'd0);
        chk("arst_ack_low", 64'(madd_ack), 64'd0);
        @(posedge clk);
        #4;
        chk("arst_held_ack_low", 64'(madd_ack), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        run_cycle();
        chk("arst_release_ack", 64'(o_madd_ack), 64'd1);
        madd_done = 1'b0;
        wb_ack = 1'b1;
        repeat (2) run_cycle();

        // Continuous madd traffic against a waiting mul.
        madd_done = 1'b1; new_madd();
        mul_done = 1'b1; new_mul();
        for (int i = 0; i < 20; i++) begin
            run_cycle();
            if (o_mul_ack) mul_ack_at.push_back(i);
            if (g_madd) new_madd();
            if (g_mul) new_mul();
        end
`ifdef FP_WB_ARB_STARVATION_EN
        chk("starve_count", 64'(mul_ack_at.size()), 64'd4);
        chk("starve_first", 64'(mul_ack_at.size() > 0 ? mul_ack_at[0] : -1), 64'd4);
        chk("starve_second", 64'(mul_ack_at.size() > 1 ? mul_ack_at[1] : -1), 64'd9);
`else
        chk("no_starve_mul_acks", 64'(mul_ack_at.size()), 64'd0);
`endif
        madd_done = 1'b0;
        mul_done = 1'b0;
        repeat (3) run_cycle();

        // Randomized traffic and backpressure.
        for (int i = 0; i < 400; i++) begin
            if (!madd_done || g_madd) begin
                madd_done = ($urandom_range(2, 0) != 0);
                new_madd();
            end
            if (!mul_done || g_mul) begin
                mul_done = ($urandom_range(2, 0) != 0);
                new_mul();
            end
            wb_ack = ($urandom_range(3, 0) != 0);
            run_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
